// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used to count pipeline stall cycles.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and data ports onto a single memory port,
// with flush-aware fetch dropping and a stall-cycle counter.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [AW-1:0]    if_addr_i,
  output logic [DW-1:0]    if_rdata_o,
  output logic             if_ack_o,
  input  logic             dm_req_i,
  input  logic             dm_we_i,
  input  logic [AW-1:0]    dm_addr_i,
  input  logic [DW-1:0]    dm_wdata_i,
  output logic [DW-1:0]    dm_rdata_o,
  output logic             dm_ack_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i,
  input  logic             mem_ready_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_t          state;
  state_t          state_nxt;
  gnt_t            last_gnt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            drop_q;
  logic            gnt_if;
  logic            gnt_dm;
  logic            if_ok;
  logic            done;

  // A flushed fetch may never be granted; a tie alternates owners.
  assign if_ok  = if_req_i & ~flush_i;
  assign gnt_if = (state == IDLE) & if_ok &
                  (~dm_req_i | (last_gnt == GNT_DM));
  assign gnt_dm = (state == IDLE) & dm_req_i & ~gnt_if;
  assign done   = (state != IDLE) & mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          gnt_dm:  state_nxt = DM_BUSY;
          gnt_if:  state_nxt = IF_BUSY;
          default: state_nxt = IDLE;
        endcase
      end
      IF_BUSY,
      DM_BUSY: begin
        if (mem_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      drop_q   <= 1'b0;
      last_gnt <= GNT_IF;
    end else begin
      if (gnt_dm) begin
        we_q     <= dm_we_i;
        addr_q   <= dm_addr_i;
        wdata_q  <= dm_wdata_i;
        last_gnt <= GNT_DM;
      end else if (gnt_if) begin
        we_q     <= 1'b0;
        addr_q   <= if_addr_i;
        last_gnt <= GNT_IF;
      end
      if (done) begin
        drop_q <= 1'b0;
      end else if ((state == IF_BUSY) && flush_i) begin
        drop_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o   = (state != IDLE);
    mem_we_o    = (state == DM_BUSY) & we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    if_ack_o    = (state == IF_BUSY) & mem_ready_i &
                  ~drop_q & ~flush_i;
    dm_ack_o    = (state == DM_BUSY) & mem_ready_i;
    if_rdata_o  = if_ack_o ? mem_rdata_i : '0;
    dm_rdata_o  = dm_ack_o ? mem_rdata_i : '0;
    stall_o     = (if_req_i & ~if_ack_o & ~flush_i) |
                  (dm_req_i & ~dm_ack_o);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (stall_o),
    .cnt   (stall_cnt_o)
  );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table,
// directed corner sequences and a randomized run against a model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        ready = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_req, mem_we, stall;
  logic [15:0] stall_cnt;

  logic [31:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata;
  logic        s_if_ack, s_dm_ack, s_mem_req, s_mem_we, s_stall;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(ready),
    .flush_i(flush), .stall_o(stall),
    .stall_cnt_o(stall_cnt)
  );

  unified_mem_arbiter #(.AW(32), .DW(32), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(s_if_rdata), .if_ack_o(s_if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(s_dm_rdata), .dm_ack_o(s_dm_ack),
    .mem_req_o(s_mem_req), .mem_we_o(s_mem_we),
    .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ready_i(ready),
    .flush_i(flush), .stall_o(s_stall),
    .stall_cnt_o(s_cnt)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    flush  = 1'b0;
    ready  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // fields: inputs then expected outputs
  typedef struct packed {
    logic if_req;
    logic dm_req;
    logic flush;
    logic ready;
    logic e_mreq;
    logic e_we;
    logic e_ifack;
    logic e_dmack;
    logic e_stall;
  } vec_t;

  vec_t tbl[7];

  // reference model state
  int          m_own;
  bit          m_last_dm;
  bit          m_drop;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_cnt;

  initial begin
    int acks;
    int stalls;
    bit got;
    bit e_ifack, e_dmack, e_stall, e_we;
    bit if_wins;

    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_acks", {if_ack, dm_ack}, 0);
    chk("rst_mem_addr", mem_addr, 0);

    // tie-break table: DM first, then IF, then DM again
    tbl[0] = 9'b1101_00001;
    tbl[1] = 9'b1101_11011;
    tbl[2] = 9'b1101_00001;
    tbl[3] = 9'b1101_10101;
    tbl[4] = 9'b1101_00001;
    tbl[5] = 9'b1101_11011;
    tbl[6] = 9'b0000_00000;
    do_reset();
    if_addr   = 32'h20;
    dm_addr   = 32'h04;
    dm_wdata  = 32'h5;
    dm_we     = 1'b1;
    mem_rdata = 32'hA5A5_0001;
    for (int i = 0; i < 7; i++) begin
      if_req = tbl[i].if_req;
      dm_req = tbl[i].dm_req;
      flush  = tbl[i].flush;
      ready  = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_mreq);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_if_ack", i), if_ack, tbl[i].e_ifack);
      chk($sformatf("tbl%0d_dm_ack", i), dm_ack, tbl[i].e_dmack);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata,
          tbl[i].e_ifack ? mem_rdata : 32'h0);
      chk($sformatf("tbl%0d_dm_rdata", i), dm_rdata,
          tbl[i].e_dmack ? mem_rdata : 32'h0);
      if (tbl[i].e_mreq) begin
        chk($sformatf("tbl%0d_mem_addr", i), mem_addr,
            tbl[i].e_we ? 32'h04 : 32'h20);
        if (tbl[i].e_we)
          chk($sformatf("tbl%0d_wdata", i), mem_wdata, 32'h5);
      end
      tick();
    end

    // lone fetch, ready on the third busy cycle
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h10;
    mem_rdata = 32'h8C01_0000;
    acks = 0;
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ready = (c == 3);
      @(negedge clk);
      if (c == 1) chk("fetch_addr", mem_addr, 32'h10);
      if (c == 1) chk("fetch_we", mem_we, 0);
      if (if_ack) begin
        acks++;
        got = 1'b1;
        chk("fetch_rdata", if_rdata, 32'h8C01_0000);
      end
      if (stall) stalls++;
      tick();
      if (got) if_req = 1'b0;
    end
    ready = 1'b0;
    chk("fetch_ack_count", acks, 1);
    chk("fetch_stall_cycles", stalls, 3);
    chk("fetch_stall_cnt", stall_cnt, 3);

    // flush while busy: transfer completes, no ack
    if_req  = 1'b1;
    if_addr = 32'h30;
    tick();
    flush  = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    chk("flush_mem_req", mem_req, 1);
    chk("flush_mem_addr", mem_addr, 32'h30);
    tick();
    flush = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("flush_no_ack", if_ack, 0);
    chk("flush_xfer_live", mem_req, 1);
    tick();
    ready = 1'b0;
    @(negedge clk);
    chk("flush_idle", mem_req, 0);
    if_req  = 1'b1;
    if_addr = 32'h34;
    tick();
    ready = 1'b1;
    @(negedge clk);
    chk("after_flush_ack", if_ack, 1);
    chk("after_flush_rdata", if_rdata, mem_rdata);
    tick();
    idle_inputs();

    // flush coincident with ready
    if_req  = 1'b1;
    if_addr = 32'h40;
    tick();
    flush = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    chk("flushrdy_no_ack", if_ack, 0);
    chk("flushrdy_rdata", if_rdata, 0);
    chk("flushrdy_mem_req", mem_req, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("flushrdy_idle", mem_req, 0);
    tick();

    // reset in the middle of a data transfer
    do_reset();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h80;
    dm_wdata = 32'h77;
    tick();
    @(negedge clk);
    chk("rstmid_busy", mem_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_stall_cnt", stall_cnt, 0);
    ready = 1'b1;
    #1;
    chk("rstmid_no_ack", dm_ack, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    dm_req = 1'b0;
    @(negedge clk);
    chk("rstmid_late_ready", dm_ack, 0);
    chk("rstmid_idle", mem_req, 0);
    tick();
    ready   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h90;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h84;
    tick();
    @(negedge clk);
    chk("rstmid_tie_addr", mem_addr, 32'h84);
    chk("rstmid_tie_we", mem_we, 0);
    ready = 1'b1;
    #1;
    chk("rstmid_tie_dmack", dm_ack, 1);
    chk("rstmid_tie_ifack", if_ack, 0);
    tick();
    idle_inputs();
    tick();

    // saturation of a 4-bit counter
    do_reset();
    dm_req = 1'b1;
    repeat (10) tick();
    chk("sat_cnt_10", s_cnt, 10);
    repeat (10) tick();
    chk("sat_cnt_15", s_cnt, 15);
    chk("wide_cnt_20", stall_cnt, 20);
    ready = 1'b1;
    tick();
    idle_inputs();
    tick();

    // randomized run against the reference model
    do_reset();
    m_own = 0;
    m_last_dm = 1'b0;
    m_drop = 1'b0;
    m_we = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_cnt = 0;
    for (int n = 0; n < 500; n++) begin
      if_req    = ($urandom_range(0, 9) < 6);
      dm_req    = ($urandom_range(0, 9) < 5);
      dm_we     = $urandom_range(0, 1) == 1;
      flush     = ($urandom_range(0, 9) < 2);
      ready     = ($urandom_range(0, 9) < 5);
      if_addr   = $urandom;
      dm_addr   = $urandom;
      dm_wdata  = $urandom;
      mem_rdata = $urandom;
      @(negedge clk);
      e_ifack = (m_own == 1) && ready && !m_drop && !flush;
      e_dmack = (m_own == 2) && ready;
      e_stall = (if_req && !e_ifack && !flush) ||
                (dm_req && !e_dmack);
      e_we    = (m_own == 2) && m_we;
      chk("rnd_mem_req", mem_req, m_own != 0);
      chk("rnd_mem_we", mem_we, e_we);
      chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_mem_wdata", mem_wdata, m_wdata);
      chk("rnd_if_ack", if_ack, e_ifack);
      chk("rnd_dm_ack", dm_ack, e_dmack);
      chk("rnd_if_rdata", if_rdata, e_ifack ? mem_rdata : 32'h0);
      chk("rnd_dm_rdata", dm_rdata, e_dmack ? mem_rdata : 32'h0);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_stall_cnt", stall_cnt, m_cnt);
      if (e_stall && m_cnt < 65535) m_cnt++;
      if (m_own == 0) begin
        if_wins = if_req && !flush && (!dm_req || m_last_dm);
        if (if_wins) begin
          m_own = 1;
          m_addr = if_addr;
          m_we = 1'b0;
          m_last_dm = 1'b0;
        end else if (dm_req) begin
          m_own = 2;
          m_addr = dm_addr;
          m_we = dm_we;
          m_wdata = dm_wdata;
          m_last_dm = 1'b1;
        end
      end else begin
        if (m_own == 1 && flush) m_drop = 1'b1;
        if (ready) begin
          m_own = 0;
          m_drop = 1'b0;
        end
      end
      tick();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the address width.
REQ-002 SHALL have parameter DW, default 32, meaning the data width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports: clk_i  in  1  clock; rst_i  in  1  async active-low reset.
REQ-005 SHALL have the fetch ports: if_req_i  in  1  fetch request, level, held until ack; if_addr_i  in  AW  fetch address; if_rdata_o  out  DW  fetch data; if_ack_o  out  1  fetch complete.
REQ-006 SHALL have the data ports: dm_req_i  in  1  data request, level, held until ack; dm_we_i  in  1  write enable; dm_addr_i  in  AW  data address; dm_wdata_i  in  DW  write data; dm_rdata_o  out  DW  read data; dm_ack_o  out  1  data complete.
REQ-007 SHALL have the memory ports: mem_req_o  out  1  memory request; mem_we_o  out  1  memory write; mem_addr_o  out  AW  memory address; mem_wdata_o  out  DW  memory write data; mem_rdata_i  in  DW  memory read data; mem_ready_i  in  1  transfer done, rdata valid.
REQ-008 SHALL have the pipeline control ports: flush_i  in  1  cancel the in-flight fetch (branch taken); stall_o  out  1  pipeline stall; stall_cnt_o  out  CNT_W  count of stall cycles.

Function
REQ-009 SHALL implement an FSM with states IDLE, IF_BUSY and DM_BUSY.
REQ-010 SHALL, in IDLE with only dm_req_i set, latch dm_we_i, dm_addr_i and dm_wdata_i and go to DM_BUSY.
REQ-011 SHALL, in IDLE with only if_req_i set and flush_i low, latch if_addr_i and go to IF_BUSY.
REQ-012 SHALL, in IDLE with both requests set, grant IF if the previous grant was DM, and grant DM otherwise (alternating tie-break).
REQ-013 SHALL NOT grant IF in a cycle where flush_i is high while in IDLE.
REQ-014 SHALL drive mem_req_o = (state != IDLE) and drive mem_we_o, mem_addr_o and mem_wdata_o from the latched registers; mem_we_o SHALL be 0 in IF_BUSY.
REQ-015 SHALL, in a busy state with mem_ready_i high, assert the owner's ack combinationally in that same cycle, pass mem_rdata_i through to the owner's rdata output, and return to IDLE at the next edge.
REQ-016 SHALL hold mem_req_o and the latched fields constant while mem_ready_i is low; there is no timeout.
REQ-017 SHALL give a minimum latency of 1 cycle from the IDLE grant edge to ack, and SHALL be able to grant again in the cycle after an ack.
REQ-018 SHALL, when flush_i is high in IF_BUSY, set a drop flag; the memory transfer SHALL still complete, and if_ack_o SHALL stay 0 for that transfer, including when flush_i coincides with mem_ready_i.
REQ-019 SHALL clear the drop flag on return to IDLE.
REQ-020 SHALL drive stall_o = (if_req_i & ~if_ack_o & ~flush_i) | (dm_req_i & ~dm_ack_o).
REQ-021 SHALL increment stall_cnt_o on each edge where stall_o is 1, saturating at 2^CNT_W-1 with no wrap.
REQ-022 SHALL drive ack outputs to 0 and rdata outputs to 0 whenever they are not being acknowledged.

Reset
REQ-023 SHALL, while rst_i is 0, immediately force the FSM to IDLE, clear the latched fields, the drop flag and stall_cnt_o, drive mem_req_o to 0, and set the last-grant record to IF.
REQ-024 SHALL, on reset during a busy state, abandon the transfer without an ack and ignore any mem_ready_i that arrives after reset.
REQ-025 SHALL sample requests again starting from the first rising clk_i edge after rst_i returns to 1.

Structure
REQ-026 SHALL place the state enum, the grant encoding (GNT_IF, GNT_DM) and the default parameter values in a shared package, mem_arb_pkg.
REQ-027 SHALL implement the saturating stall counter as a single sub-module, sat_counter, parameterised by CNT_W; the FSM and muxing SHALL stay in the top module.

Verification
REQ-028 SHALL cover a lone fetch: if_addr 0x10, mem_ready 2 cycles after mem_req, rdata 0x8C010000 -> if_ack pulses once with rdata 0x8C010000, stall_o high for 3 cycles, stall_cnt_o = 3.
REQ-029 SHALL cover a simultaneous request: IF 0x20 and DM write 0x04/0x5, with mem_ready immediate -> DM granted first with mem_we_o=1, then IF granted in the cycle after dm_ack; with both still requesting after the IF grant, DM wins next.
REQ-030 SHALL cover a flush: flush_i pulsed in IF_BUSY on fetch 0x30 -> the transfer completes on the memory side, if_ack_o stays 0, FSM in IDLE the cycle after mem_ready.
REQ-031 SHALL cover flush coincident with ready: flush_i and mem_ready_i high in the same IF_BUSY cycle -> no if_ack_o.
REQ-032 SHALL cover reset mid-operation: rst_i low in DM_BUSY -> mem_req_o 0 with no clock edge, no dm_ack_o, stall_cnt_o 0, first tie after reset granted to DM.
REQ-033 SHALL cover saturation: CNT_W=4 with DM held stalled for 20 cycles -> stall_cnt_o stops at 15.
